// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router input path.
// Decodes the destination address, waits for the addressed FIFO to drain,
// then steps the register/synchronizer blocks through header, payload,
// FIFO-full stall, parity load and parity check.
// Optional wait watchdog: define ROUTER_FSM_WAIT_TIMEOUT_EN to build it.
module router_fsm #(
    parameter int WAIT_LIMIT = 31
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic       drop_pkt
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] addr_r;
    logic       hdr_empty_s;
    logic       cur_empty_s;
    logic       cur_soft_s;
    logic       abort_s;

    // Output strobes for a given state, packed as
    // {detect, lfd, ld, full, laf, rst_int, write_enb, busy}.
    function automatic logic [7:0] decode_outputs(input state_t s);
        logic [7:0] o;
        o = 8'b1000_0000;
        case (s)
            DECODE_ADDRESS:     o = 8'b1000_0000;
            LOAD_FIRST_DATA:    o = 8'b0100_0001;
            LOAD_DATA:          o = 8'b0010_0010;
            FIFO_FULL_STATE:    o = 8'b0001_0001;
            LOAD_AFTER_FULL:    o = 8'b0000_1011;
            LOAD_PARITY:        o = 8'b0000_0011;
            CHECK_PARITY_ERROR: o = 8'b0000_0101;
            WAIT_TILL_EMPTY:    o = 8'b0000_0001;
            default:            o = 8'b1000_0000;
        endcase
        return o;
    endfunction

    // Select the empty flag addressed by the incoming header byte.
    always_comb begin
        hdr_empty_s = 1'b0;
        case (data_in)
            2'd0:    hdr_empty_s = fifo_empty_0;
            2'd1:    hdr_empty_s = fifo_empty_1;
            2'd2:    hdr_empty_s = fifo_empty_2;
            default: hdr_empty_s = 1'b0;
        endcase
    end

    // Select the empty flag and soft reset of the latched destination.
    always_comb begin
        cur_empty_s = 1'b0;
        cur_soft_s  = 1'b0;
        case (addr_r)
            2'd0: begin
                cur_empty_s = fifo_empty_0;
                cur_soft_s  = soft_reset_0;
            end
            2'd1: begin
                cur_empty_s = fifo_empty_1;
                cur_soft_s  = soft_reset_1;
            end
            2'd2: begin
                cur_empty_s = fifo_empty_2;
                cur_soft_s  = soft_reset_2;
            end
            default: begin
                cur_empty_s = 1'b0;
                cur_soft_s  = 1'b0;
            end
        endcase
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);
    logic [7:0] wait_cnt_r;

    // Watchdog fires on the last allowed wait cycle; an empty FIFO or a
    // soft reset in that same cycle takes precedence.
    always_comb begin
        abort_s = (state_r == WAIT_TILL_EMPTY) && !cur_empty_s && !cur_soft_s &&
                  (wait_cnt_r == LIMIT_M1);
    end

    // Count cycles spent in WAIT_TILL_EMPTY, clearing on entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r != WAIT_TILL_EMPTY && next_state_s == WAIT_TILL_EMPTY) begin
            wait_cnt_r <= 8'd0;
        end else if (state_r == WAIT_TILL_EMPTY && next_state_s == WAIT_TILL_EMPTY) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Drop pulse lands in the first DECODE_ADDRESS cycle after an abort.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drop_pkt <= 1'b0;
        end else begin
            drop_pkt <= abort_s;
        end
    end
`else
    logic unused_wait_limit;
    assign unused_wait_limit = ^(8'(WAIT_LIMIT));
    assign abort_s  = 1'b0;
    assign drop_pkt = 1'b0;
`endif

    // Next-state selection; soft reset of the addressed FIFO overrides all.
    always_comb begin
        next_state_s = state_r;
        if (state_r != DECODE_ADDRESS && cur_soft_s) begin
            next_state_s = DECODE_ADDRESS;
        end else if (abort_s) begin
            next_state_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        next_state_s = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        next_state_s = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: next_state_s = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        next_state_s = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: next_state_s = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        next_state_s = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        next_state_s = LOAD_PARITY;
                    end else begin
                        next_state_s = LOAD_DATA;
                    end
                end
                LOAD_PARITY:        next_state_s = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: next_state_s = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:    next_state_s = cur_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                default:            next_state_s = DECODE_ADDRESS;
            endcase
        end
    end

    // State, latched address and state strobes; strobes are decoded from the
    // next state so they are registered yet line up with the state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= DECODE_ADDRESS;
            addr_r  <= 2'd0;
            {detect_add, lfd_state, ld_state, full_state, laf_state,
             rst_int_reg, write_enb_reg, busy} <= 8'b1000_0000;
        end else begin
            state_r <= next_state_s;
            if (state_r == DECODE_ADDRESS && pkt_valid) begin
                addr_r <= data_in;
            end else begin
                addr_r <= addr_r;
            end
            {detect_add, lfd_state, ld_state, full_state, laf_state,
             rst_int_reg, write_enb_reg, busy} <= decode_outputs(next_state_s);
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: spec-level model compared every cycle,
// plus hand-computed expectations along directed packet scenarios.
module tb_router_fsm;

    localparam int WL = 4;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int T2W = 3;
`else
    localparam int T2W = 5;
`endif

    // Abstract state numbers as listed in the state table.
    localparam int S_DEC = 0, S_LFD = 1, S_LD = 2, S_FULL = 3,
                   S_LAF = 4, S_LP = 5, S_CPE = 6, S_WAIT = 7;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, full_state, laf_state;
    logic       rst_int_reg, write_enb_reg, busy, drop_pkt;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;
    int we_cnt, rst_cnt;

    logic [8:0] outv;
    logic [2:0] emp_v, sr_v;
    assign outv  = {detect_add, lfd_state, ld_state, full_state, laf_state,
                    rst_int_reg, write_enb_reg, busy, drop_pkt};
    assign emp_v = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign sr_v  = {soft_reset_2, soft_reset_1, soft_reset_0};

    always #5 clock = ~clock;

    router_fsm #(.WAIT_LIMIT(WL)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy), .drop_pkt(drop_pkt)
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Output strobes implied by an abstract state, from the output list.
    function automatic logic [8:0] exp_vec(input int s, input bit d);
        logic busy_e;
        logic we_e;
        busy_e = !(s == S_DEC || s == S_LD);
        we_e   = (s == S_LD || s == S_LP || s == S_LAF);
        return {s == S_DEC, s == S_LFD, s == S_LD, s == S_FULL, s == S_LAF,
                s == S_CPE, we_e, busy_e, d};
    endfunction

    int         m_state;
    logic [1:0] m_addr;
    int         m_wcnt;
    bit         m_drop;

    // Reference model of the packet sequencing rules.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_state <= S_DEC;
            m_addr  <= 2'd0;
            m_wcnt  <= 0;
            m_drop  <= 1'b0;
        end else begin
            m_drop <= 1'b0;
            if (m_state == S_DEC && pkt_valid) m_addr <= data_in;
            if (m_state != S_DEC && sr_v[m_addr]) begin
                m_state <= S_DEC;
            end else begin
                case (m_state)
                    S_DEC: if (pkt_valid && data_in != 2'd3) begin
                        m_state <= emp_v[data_in] ? S_LFD : S_WAIT;
                        m_wcnt  <= 0;
                    end
                    S_LFD:  m_state <= S_LD;
                    S_LD:   m_state <= fifo_full ? S_FULL : (!pkt_valid ? S_LP : S_LD);
                    S_FULL: m_state <= fifo_full ? S_FULL : S_LAF;
                    S_LAF:  m_state <= parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
                    S_LP:   m_state <= S_CPE;
                    S_CPE:  m_state <= fifo_full ? S_FULL : S_DEC;
                    S_WAIT: begin
                        if (emp_v[m_addr]) begin
                            m_state <= S_LFD;
                        end else begin
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
                            if (m_wcnt + 1 >= WL) begin
                                m_state <= S_DEC;
                                m_drop  <= 1'b1;
                            end else begin
                                m_wcnt <= m_wcnt + 1;
                            end
`else
                            m_wcnt <= m_wcnt + 1;
`endif
                        end
                    end
                    default: m_state <= S_DEC;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (check_en) chk("model", outv, exp_vec(m_state, m_drop));
    end

    task automatic cyc;
        @(posedge clock);
        #2;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("reset", outv, 9'b100000000);
        resetn = 1'b1;
        check_en = 1'b1;

        // Packet to address 1, three payload bytes.
        pkt_valid = 1'b1; data_in = 2'd1;
        cyc; chk("t1_lfd", outv, 9'b010000010);
        we_cnt = 0; rst_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            pkt_valid = (i < 3);
            cyc;
            we_cnt  += int'(write_enb_reg);
            rst_cnt += int'(rst_int_reg);
        end
        chk("t1_we_cycles", 9'(we_cnt), 9'd4);
        chk("t1_rst_int_pulses", 9'(rst_cnt), 9'd1);
        chk("t1_back_to_decode", outv, 9'b100000000);

        // Address 2 not empty: wait, then load first data.
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        for (int i = 0; i < T2W; i++) begin
            cyc; chk("t2_wait", outv, 9'b000000010);
        end
        fifo_empty_2 = 1'b1;
        cyc; chk("t2_lfd", outv, 9'b010000010);
        cyc; chk("t2_ld", outv, 9'b001000100);

        // FIFO full mid-payload for three cycles.
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc; chk("t3_full", outv, 9'b000100010);
        end
        fifo_full = 1'b0;
        cyc; chk("t3_laf", outv, 9'b000010110);
        cyc; chk("t3_ld_again", outv, 9'b001000100);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        cyc; chk("t3_full_wins", outv, 9'b000100010);
        fifo_full = 1'b0;
        cyc; chk("t3_laf2", outv, 9'b000010110);
        low_pkt_valid = 1'b1;
        cyc; chk("t3_lp", outv, 9'b000000110);
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        cyc; chk("t3_cpe", outv, 9'b000001010);
        cyc; chk("t3_cpe_to_full", outv, 9'b000100010);
        fifo_full = 1'b0;
        cyc; chk("t3_laf3", outv, 9'b000010110);
        parity_done = 1'b1;
        cyc; chk("t3_parity_done", outv, 9'b100000000);
        parity_done = 1'b0;

        // Soft reset: other FIFO ignored, addressed FIFO aborts.
        pkt_valid = 1'b1; data_in = 2'd0;
        cyc; cyc; chk("t4_ld", outv, 9'b001000100);
        soft_reset_1 = 1'b1;
        cyc; chk("t4_sr1_ignored", outv, 9'b001000100);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
        cyc; chk("t4_sr0_abort", outv, 9'b100000000);
        soft_reset_0 = 1'b0;

        // Address 3 is ignored.
        pkt_valid = 1'b1; data_in = 2'd3;
        cyc; chk("t5_addr3", outv, 9'b100000000);
        cyc; chk("t5_addr3_hold", outv, 9'b100000000);

        // Destination never empties.
        fifo_empty_1 = 1'b0; data_in = 2'd1;
        for (int i = 0; i < WL; i++) begin
            cyc; chk("t6_wait", outv, 9'b000000010);
            pkt_valid = 1'b0;
        end
        cyc;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        chk("t6_drop", outv, 9'b100000001);
        cyc; chk("t6_drop_single", outv, 9'b100000000);
        pkt_valid = 1'b1;
        cyc; pkt_valid = 1'b0;
`else
        chk("t6_still_wait", outv, 9'b000000010);
`endif
        cyc; chk("t7_wait_before_reset", outv, 9'b000000010);
        resetn = 1'b0;
        #1; chk("t7_async_reset", outv, 9'b100000000);
        @(posedge clock); #2;
        resetn = 1'b1;

        // Empty arrives in the cycle the watchdog limit is reached.
        pkt_valid = 1'b1; data_in = 2'd1;
        cyc; pkt_valid = 1'b0;
        repeat (WL - 1) cyc;
        chk("t8_wait_at_limit", outv, 9'b000000010);
        fifo_empty_1 = 1'b1;
        cyc; chk("t8_empty_wins", outv, 9'b010000010);
        repeat (4) cyc;
        chk("t8_done", outv, 9'b100000000);

        cyc;
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
